dot_seq_feeder: RTL and testbench

//  Upstream operand sequencer for the fma accumulator. Buffers (a,b) operand pairs from a

---
 rtl/dot_seq_pkg.sv | 21 ++
 rtl/dot_seq_fifo.sv | 62 ++++++
 rtl/dot_seq_feeder.sv | 121 ++++++++++++
 tb/tb_dot_seq_feeder.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_seq_pkg.sv
// ============================================================================
// Module  : dot_seq_pkg
// Brief   : Shared types for the dot-product operand sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dot_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dot_seq_fifo.sv
// ============================================================================
// Module  : dot_seq_fifo
// Brief   : Synchronous FIFO for operand pairs with flush; no write-to-read bypass.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dot_seq_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // Flush takes priority so an aborting job cannot leave a stray pair behind.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

`default_nettype wire

// File: rtl/dot_seq_feeder.sv
// ============================================================================
// Module  : dot_seq_feeder
// Brief   : Buffers operand pairs and streams a job of len pairs into an fma.
//           Optional abort input enabled by defining DOT_SEQ_ABORT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dot_seq_feeder
  import dot_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef DOT_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] fma_ina,
  output logic [WIDTH-1:0] fma_inb,
  output logic             fma_enable,
  output logic             fma_clear,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] issued
);

  state_t             state;
  state_t             state_nxt;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   issued_inc;
  logic               abort_req;
  logic               fifo_full;
  logic               fifo_empty;
  logic [2*WIDTH-1:0] fifo_head;

`ifdef DOT_SEQ_ABORT_EN
  assign abort_req = abort && ((state == ST_CLEAR) || (state == ST_RUN));
`else
  assign abort_req = 1'b0;
`endif

  dot_seq_fifo #(
    .WIDTH (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (abort_req),
    .push  (in_valid),
    .pop   (fma_enable),
    .wdata ({in_a, in_b}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A pair offered during an abort is dropped, so it must not see a handshake.
  assign in_ready   = !fifo_full && !abort_req;
  assign fma_ina    = fifo_head[2*WIDTH-1:WIDTH];
  assign fma_inb    = fifo_head[WIDTH-1:0];
  assign fma_clear  = reset || (state == ST_CLEAR);
  assign issued_inc = issued + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Leaving RUN on the last enable puts done one cycle after the final accumulate.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_CLEAR;
      ST_CLEAR: state_nxt = ST_RUN;
      ST_RUN:   if ((issued == len_q) || (fma_enable && (issued_inc == len_q)))
                  state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort_req) state_nxt = ST_IDLE;
  end

  always_comb begin
    fma_enable = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_CLEAR: busy = 1'b1;
      ST_RUN: begin
        busy       = 1'b1;
        fma_enable = (issued != len_q) && !fifo_empty && !abort_req;
      end
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issued <= '0;
      len_q  <= '0;
    end else if ((state == ST_IDLE) && start) begin
      issued <= '0;
      len_q  <= len;
    end else if (fma_enable) begin
      issued <= issued_inc;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dot_seq_feeder.sv
// ============================================================================
// Module  : tb_dot_seq_feeder
// Brief   : Directed bench for dot_seq_feeder with a behavioural fma accumulator.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dot_seq_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
`ifdef DOT_SEQ_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic [7:0]  fma_ina;
  logic [7:0]  fma_inb;
  logic        fma_enable;
  logic        fma_clear;
  logic        busy;
  logic        done;
  logic [7:0]  issued;
  logic [23:0] acc;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  dot_seq_feeder #(.WIDTH(8), .DEPTH(4), .LEN_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
`ifdef DOT_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .fma_ina    (fma_ina),
    .fma_inb    (fma_inb),
    .fma_enable (fma_enable),
    .fma_clear  (fma_clear),
    .busy       (busy),
    .done       (done),
    .issued     (issued)
  );

  // Downstream multiply-accumulate unit
  always @(posedge clk) begin
    if (fma_clear)       acc <= '0;
    else if (fma_enable) acc <= acc + {16'b0, fma_ina} * {16'b0, fma_inb};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    bit ok = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 50; i++) begin
      if (in_ready === 1'b1) begin
        ok = 1;
        step();
        break;
      end
      step();
    end
    in_valid = 1'b0;
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL push_timeout: in_ready=%b required 1 within 50 cycles", in_ready);
    end
  endtask

  task automatic start_job(input logic [7:0] l);
    start = 1'b1;
    len = l;
    step();
    start = 1'b0;
  endtask

  // Walks the job from the CLEAR cycle (index 0) and stops while done is high.
  task automatic run_until_done(input int maxc, output int en_cnt, output int first_en,
                                output int last_en, output int done_i);
    en_cnt = 0; first_en = -1; last_en = -1; done_i = -1;
    for (int i = 0; i < maxc; i++) begin
      if (done === 1'b1) begin
        done_i = i;
        break;
      end
      if (fma_enable === 1'b1) begin
        en_cnt++;
        if (first_en < 0) first_en = i;
        last_en = i;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    compared++;
    if ({busy, done, fma_enable, fma_clear, in_ready} !== 5'b00011) begin
      mismatched++;
      $display("FAIL reset_ctrl: busy/done/en/clear/ready=%b required 00011",
               {busy, done, fma_enable, fma_clear, in_ready});
    end
    compared++;
    if (issued !== 8'd0) begin
      mismatched++;
      $display("FAIL reset_issued: got %0d required 0", issued);
    end
    reset = 1'b0;
    step();
    compared++;
    if (fma_clear !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release: clear=%b busy=%b required 0 0", fma_clear, busy);
    end
  endtask

  task automatic test_prefill_len3();
    int n, f, l, d;
    push_pair(8'd2, 8'd3);
    push_pair(8'd4, 8'd5);
    push_pair(8'd6, 8'd7);
    compared++;
    if (busy !== 1'b0 || fma_enable !== 1'b0) begin
      mismatched++;
      $display("FAIL prefill_idle: busy=%b en=%b required 0 0", busy, fma_enable);
    end
    start_job(8'd3);
    compared++;
    if (fma_clear !== 1'b1 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL prefill_clear: clear=%b busy=%b required 1 1", fma_clear, busy);
    end
    run_until_done(20, n, f, l, d);
    compared++;
    if (n != 3 || f != 1 || l != 3 || d != 4) begin
      mismatched++;
      $display("FAIL prefill_timing: en=%0d first=%0d last=%0d done=%0d required 3 1 3 4", n, f, l, d);
    end
    compared++;
    if (acc !== 24'd68 || issued !== 8'd3) begin
      mismatched++;
      $display("FAIL prefill_result: acc=%0d issued=%0d required 68 3", acc, issued);
    end
    step();
    compared++;
    if (done !== 1'b0 || busy !== 1'b0 || issued !== 8'd3) begin
      mismatched++;
      $display("FAIL prefill_idle_hold: done=%b busy=%b issued=%0d required 0 0 3", done, busy, issued);
    end
  endtask

  task automatic test_len0();
    start_job(8'd0);
    compared++;
    if (fma_clear !== 1'b1) begin
      mismatched++;
      $display("FAIL len0_clear: got %b required 1", fma_clear);
    end
    step();
    compared++;
    if (fma_clear !== 1'b0 || fma_enable !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL len0_run: clear=%b en=%b done=%b required 0 0 0", fma_clear, fma_enable, done);
    end
    step();
    compared++;
    if (done !== 1'b1 || acc !== 24'd0 || issued !== 8'd0) begin
      mismatched++;
      $display("FAIL len0_done: done=%b acc=%0d issued=%0d required 1 0 0", done, acc, issued);
    end
    step();
  endtask

  task automatic test_gaps();
    int n, f, l, d;
    logic [7:0] va [4] = '{8'd1, 8'd2, 8'd3, 8'd1};
    logic [7:0] vb [4] = '{8'd1, 8'd2, 8'd3, 8'd2};
    start_job(8'd4);
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          push_pair(va[k], vb[k]);
          repeat (2) step();
        end
      end
      run_until_done(40, n, f, l, d);
    join
    compared++;
    if (n != 4 || d != l + 1 || (l - f) <= 3) begin
      mismatched++;
      $display("FAIL gaps_timing: en=%0d first=%0d last=%0d done=%0d required 4 gapped, done=last+1", n, f, l, d);
    end
    compared++;
    if (acc !== 24'd16 || issued !== 8'd4) begin
      mismatched++;
      $display("FAIL gaps_result: acc=%0d issued=%0d required 16 4", acc, issued);
    end
    step();
  endtask

  task automatic test_fill();
    int n, f, l, d;
    for (int k = 0; k < 4; k++) push_pair(8'(k + 1), 8'd1);
    in_valid = 1'b1;
    in_a = 8'd5;
    in_b = 8'd1;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL fill_full: in_ready=%b required 0", in_ready);
    end
    start_job(8'd6);
    fork
      begin
        push_pair(8'd5, 8'd1);
        push_pair(8'd6, 8'd1);
      end
      run_until_done(40, n, f, l, d);
    join
    compared++;
    if (n != 6 || d < 0) begin
      mismatched++;
      $display("FAIL fill_enables: en=%0d done_at=%0d required 6 and done", n, d);
    end
    compared++;
    if (acc !== 24'd21 || issued !== 8'd6) begin
      mismatched++;
      $display("FAIL fill_result: acc=%0d issued=%0d required 21 6", acc, issued);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int n, f, l, d;
    bit hit = 0;
    bit saw_en = 0;
    bit saw_done = 0;
    for (int k = 0; k < 4; k++) push_pair(8'd1, 8'd1);
    start_job(8'd5);
    for (int i = 0; i < 20; i++) begin
      if (issued === 8'd2) begin
        hit = 1;
        break;
      end
      step();
    end
    compared++;
    if (!hit) begin
      mismatched++;
      $display("FAIL rstmid_reach: issued=%0d required 2 within 20 cycles", issued);
    end
    reset = 1'b1;
    #1;
    compared++;
    if (fma_clear !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_clear: got %b required 1", fma_clear);
    end
    step();
    reset = 1'b0;
    #1;
    compared++;
    if ({busy, done, in_ready} !== 3'b001 || issued !== 8'd0 || acc !== 24'd0) begin
      mismatched++;
      $display("FAIL rstmid_state: busy/done/ready=%b issued=%0d acc=%0d required 001 0 0",
               {busy, done, in_ready}, issued, acc);
    end
    start_job(8'd1);
    for (int i = 0; i < 4; i++) begin
      if (fma_enable === 1'b1) saw_en = 1;
      if (done === 1'b1) saw_done = 1;
      step();
    end
    compared++;
    if (saw_en || saw_done || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_empty: en_seen=%b done_seen=%b busy=%b required 0 0 1", saw_en, saw_done, busy);
    end
    push_pair(8'd3, 8'd4);
    run_until_done(10, n, f, l, d);
    compared++;
    if (d < 0 || acc !== 24'd12 || issued !== 8'd1) begin
      mismatched++;
      $display("FAIL rstmid_rerun: done_at=%0d acc=%0d issued=%0d required done 12 1", d, acc, issued);
    end
    step();
  endtask

`ifdef DOT_SEQ_ABORT_EN
  task automatic test_abort();
    bit hit = 0;
    bit saw_done = 0;
    for (int k = 0; k < 3; k++) push_pair(8'd1, 8'd2);
    start_job(8'd3);
    for (int i = 0; i < 20; i++) begin
      if (issued === 8'd1) begin
        hit = 1;
        break;
      end
      step();
    end
    abort = 1'b1;
    #1;
    compared++;
    if (!hit || fma_enable !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_cycle: reached=%b en=%b required 1 0", hit, fma_enable);
    end
    step();
    abort = 1'b0;
    #1;
    compared++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_idle: busy=%b done=%b required 0 0", busy, done);
    end
    for (int k = 0; k < 3; k++) begin
      if (done === 1'b1) saw_done = 1;
      push_pair(8'd1, 8'd1);
    end
    compared++;
    if (in_ready !== 1'b1 || saw_done) begin
      mismatched++;
      $display("FAIL abort_flush: in_ready=%b done_seen=%b required 1 0", in_ready, saw_done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_prefill_len3();
    test_len0();
    test_gaps();
    test_fill();
    test_reset_mid();
`ifdef DOT_SEQ_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded 200000");
    $fatal(1);
  end

endmodule

`default_nettype wire
